// File: rtl/pc_sequencer_if.sv
// Control/instruction-memory side signals of the program-counter sequencer.
// The master drives selects and targets; the slave (sequencer) returns PC and RAS status.
interface pc_sequencer_if #(
    parameter int WIDTH = 16
) ();
    logic [2:0]       pcSrc;
    logic [WIDTH-1:0] immAddr;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] mary;
    logic             comp;
    logic             pcWrite;
    logic             call;
    logic [WIDTH-1:0] pcOut;
    logic [WIDTH-1:0] rasTop;
    logic             rasEmpty;
    logic             rasFull;
    logic             rasOvf;
    logic             rasUnf;

    modport master (
        output pcSrc, immAddr, ra, mary, comp, pcWrite, call,
        input  pcOut, rasTop, rasEmpty, rasFull, rasOvf, rasUnf
    );

    modport slave (
        input  pcSrc, immAddr, ra, mary, comp, pcWrite, call,
        output pcOut, rasTop, rasEmpty, rasFull, rasOvf, rasUnf
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC register with an eight-way next-PC select and a circular return-address stack.
// All outputs come straight from registered state; inputs only steer the next edge.
module pc_sequencer #(
    parameter int               WIDTH     = 16,
    parameter int               STEP      = 2,
    parameter int               RAS_DEPTH = 8,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input logic           clock,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);

    localparam logic [2:0] SRC_SEQ    = 3'b000;
    localparam logic [2:0] SRC_BRANCH = 3'b001;
    localparam logic [2:0] SRC_IMM    = 3'b010;
    localparam logic [2:0] SRC_RA     = 3'b011;
    localparam logic [2:0] SRC_MARY   = 3'b100;
    localparam logic [2:0] SRC_REL4   = 3'b101;
    localparam logic [2:0] SRC_RET    = 3'b110;
    localparam logic [2:0] SRC_IMM4   = 3'b111;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [WIDTH-1:0] top_val;
    logic [PTR_W-1:0] top;
    logic [PTR_W-1:0] top_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             ovf;
    logic             ovf_next;
    logic             unf;
    logic             unf_next;
    logic             empty;
    logic             full;
    logic             is_ret;
    logic             mem_we;
    logic [PTR_W-1:0] mem_addr;

    assign pc_inc  = pc + STEP_W;
    assign empty   = (count == '0);
    assign full    = (count == CNT_MAX);
    assign top_val = empty ? '0 : ras_mem[top];
    assign is_ret  = (bus.pcSrc == SRC_RET);

    always_comb begin
        pc_next = pc_inc;
        unique case (bus.pcSrc)
            SRC_SEQ:    pc_next = pc_inc;
            SRC_BRANCH: pc_next = bus.comp ? (pc + bus.immAddr) : pc_inc;
            SRC_IMM:    pc_next = bus.immAddr;
            SRC_RA:     pc_next = bus.ra;
            SRC_MARY:   pc_next = bus.mary;
            SRC_REL4:   pc_next = pc + (bus.mary << 4);
            SRC_RET:    pc_next = empty ? bus.ra : top_val;
            SRC_IMM4:   pc_next = bus.immAddr << 4;
            default:    pc_next = pc_inc;
        endcase
    end

    // Return with a live entry and call together rewrites the top in place.
    // An empty-stack return with call falls through to a normal push.
    always_comb begin
        top_next   = top;
        count_next = count;
        ovf_next   = ovf;
        unf_next   = unf;
        mem_we     = 1'b0;
        mem_addr   = top + PTR_W'(1);
        if (bus.pcWrite) begin
            if (is_ret && !empty) begin
                if (bus.call) begin
                    mem_we   = 1'b1;
                    mem_addr = top;
                end else begin
                    top_next   = top - PTR_W'(1);
                    count_next = count - CNT_W'(1);
                end
            end else begin
                if (is_ret) begin
                    unf_next = 1'b1;
                end
                if (bus.call) begin
                    mem_we   = 1'b1;
                    mem_addr = top + PTR_W'(1);
                    top_next = top + PTR_W'(1);
                    if (full) begin
                        ovf_next = 1'b1;
                    end else begin
                        count_next = count + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc    <= RESET_PC;
            top   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (bus.pcWrite) begin
                pc <= pc_next;
            end
            top   <= top_next;
            count <= count_next;
            ovf   <= ovf_next;
            unf   <= unf_next;
        end
    end

    // Entry contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            ras_mem[mem_addr] <= pc_inc;
        end
    end

    assign bus.pcOut    = pc;
    assign bus.rasTop   = top_val;
    assign bus.rasEmpty = empty;
    assign bus.rasFull  = full;
    assign bus.rasOvf   = ovf;
    assign bus.rasUnf   = unf;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic against a queue-based model.
module tb_pc_sequencer;
    localparam int W     = 16;
    localparam int DEPTH = 8;

    logic clock = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    pc_sequencer_if #(.WIDTH(W)) bus ();

    pc_sequencer #(
        .WIDTH(W), .STEP(2), .RAS_DEPTH(DEPTH), .RESET_PC(16'h0000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    // Reference model: stack as a queue, back = top, front = oldest.
    logic [W-1:0] m_pc;
    logic [W-1:0] m_stack[$];
    logic         m_ovf;
    logic         m_unf;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = '0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] src, input logic [W-1:0] imm, input logic [W-1:0] r,
                              input logic [W-1:0] m, input logic c, input logic w, input logic cl);
        logic [W-1:0] nxt;
        logic [W-1:0] ret_addr;
        logic [W-1:0] shifted;
        bit           has;
        if (!w) return;
        ret_addr = m_pc + 16'd2;
        has      = (m_stack.size() > 0);
        case (src)
            3'd0: nxt = m_pc + 16'd2;
            3'd1: nxt = c ? m_pc + imm : m_pc + 16'd2;
            3'd2: nxt = imm;
            3'd3: nxt = r;
            3'd4: nxt = m;
            3'd5: begin shifted = m * 16; nxt = m_pc + shifted; end
            3'd6: begin
                if (has) nxt = m_stack[m_stack.size()-1];
                else     nxt = r;
            end
            default: begin shifted = imm * 16; nxt = shifted; end
        endcase
        if (src == 3'd6 && has && cl) begin
            m_stack[m_stack.size()-1] = ret_addr;
        end else if (src == 3'd6 && has) begin
            void'(m_stack.pop_back());
        end else begin
            if (src == 3'd6) m_unf = 1'b1;
            if (cl) begin
                if (m_stack.size() == DEPTH) begin
                    void'(m_stack.pop_front());
                    m_ovf = 1'b1;
                end
                m_stack.push_back(ret_addr);
            end
        end
        m_pc = nxt;
    endtask

    task automatic compare_all(input string tag);
        logic [W-1:0] exp_top;
        exp_top = (m_stack.size() > 0) ? m_stack[m_stack.size()-1] : '0;
        check_val({tag, ".pcOut"},    32'(bus.pcOut),    32'(m_pc));
        check_val({tag, ".rasTop"},   32'(bus.rasTop),   32'(exp_top));
        check_val({tag, ".rasEmpty"}, 32'(bus.rasEmpty), 32'(m_stack.size() == 0));
        check_val({tag, ".rasFull"},  32'(bus.rasFull),  32'(m_stack.size() == DEPTH));
        check_val({tag, ".rasOvf"},   32'(bus.rasOvf),   32'(m_ovf));
        check_val({tag, ".rasUnf"},   32'(bus.rasUnf),   32'(m_unf));
    endtask

    task automatic apply(input string tag, input logic [2:0] src, input logic [W-1:0] imm,
                         input logic [W-1:0] r, input logic [W-1:0] m, input logic c,
                         input logic w, input logic cl, input logic rs);
        bus.pcSrc   = src;
        bus.immAddr = imm;
        bus.ra      = r;
        bus.mary    = m;
        bus.comp    = c;
        bus.pcWrite = w;
        bus.call    = cl;
        reset       = rs;
        @(posedge clock);
        #1;
        if (rs) model_reset();
        else    model_step(src, imm, r, m, c, w, cl);
        compare_all(tag);
    endtask

    task automatic do_reset();
        apply("reset", 3'd0, '0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic jump(input logic [W-1:0] target);
        apply("jump", 3'd2, target, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] pc_hold;
        model_reset();
        bus.pcSrc = '0; bus.immAddr = '0; bus.ra = '0; bus.mary = '0;
        bus.comp = 1'b0; bus.pcWrite = 1'b0; bus.call = 1'b0; reset = 1'b1;

        do_reset();
        check_val("rst_pc", 32'(bus.pcOut), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            apply("seq", 3'd0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
            check_val("seq_pc", 32'(bus.pcOut), 32'(2 * i));
        end

        jump(16'h0010);
        apply("br_taken", 3'd1, 16'h0020, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("br_taken_pc", 32'(bus.pcOut), 32'h0030);
        jump(16'h0010);
        apply("br_not", 3'd1, 16'h0020, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("br_not_pc", 32'(bus.pcOut), 32'h0012);
        jump(16'hFFFE);
        apply("wrap", 3'd0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("wrap_pc", 32'(bus.pcOut), 32'h0000);

        jump(16'h0100);
        apply("call", 3'd2, 16'h0400, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("call_pc", 32'(bus.pcOut), 32'h0400);
        check_val("call_top", 32'(bus.rasTop), 32'h0102);
        check_val("call_empty", 32'(bus.rasEmpty), 32'h0);
        apply("ret", 3'd6, '0, 16'hDEAD, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("ret_pc", 32'(bus.pcOut), 32'h0102);
        check_val("ret_empty", 32'(bus.rasEmpty), 32'h1);

        do_reset();
        for (int k = 1; k <= 9; k++) begin
            apply("push9", 3'd2, 16'(16'h1000 + 16'h0100 * k), '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        check_val("ovf_full", 32'(bus.rasFull), 32'h1);
        check_val("ovf_flag", 32'(bus.rasOvf), 32'h1);
        // Return addresses are 0x0002 then 0x1102..0x1802; the first one got overwritten.
        for (int k = 8; k >= 1; k--) begin
            apply("pop8", 3'd6, '0, 16'hBEEF, '0, 1'b0, 1'b1, 1'b0, 1'b0);
            check_val("pop8_pc", 32'(bus.pcOut), 32'(16'h1002 + 16'h0100 * k));
        end
        apply("pop_unf", 3'd6, '0, 16'hBEEF, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("unf_pc", 32'(bus.pcOut), 32'hBEEF);
        check_val("unf_flag", 32'(bus.rasUnf), 32'h1);

        do_reset();
        jump(16'h01FE);
        apply("call200", 3'd2, 16'h0300, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        apply("poppush", 3'd6, '0, 16'h5555, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("pp_pc", 32'(bus.pcOut), 32'h0200);
        check_val("pp_top", 32'(bus.rasTop), 32'h0302);
        apply("pp_pop", 3'd6, '0, 16'h5555, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("pp_count1", 32'(bus.rasEmpty), 32'h1);

        pc_hold = bus.pcOut;
        for (int i = 0; i < 4; i++) begin
            apply("stall", 3'd2, 16'h7777, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
            check_val("stall_pc", 32'(bus.pcOut), 32'(pc_hold));
            check_val("stall_empty", 32'(bus.rasEmpty), 32'h1);
        end
        apply("call_pre", 3'd2, 16'h0800, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        apply("rst_call", 3'd2, 16'h0900, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        check_val("rst_call_pc", 32'(bus.pcOut), 32'h0);
        check_val("rst_call_empty", 32'(bus.rasEmpty), 32'h1);
        check_val("rst_call_ovf", 32'(bus.rasOvf), 32'h0);

        for (int i = 0; i < 600; i++) begin
            logic [2:0] src;
            logic       cl;
            src = ($urandom_range(0, 3) == 0) ? 3'd6 : 3'($urandom_range(0, 7));
            cl  = ($urandom_range(0, 2) == 0);
            apply("rand", src, 16'($urandom), 16'($urandom), 16'($urandom),
                  1'($urandom), ($urandom_range(0, 5) != 0), cl, ($urandom_range(0, 60) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
